// File: rtl/rgb_pwm_fader_if.sv
// Write port of the PWM fader: valid/ready handshake carrying channel, duty and mode.
interface rgb_pwm_fader_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_chan;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_mode;

    modport master (output wr_valid, wr_chan, wr_duty, wr_mode, input wr_ready);
    modport slave  (input wr_valid, wr_chan, wr_duty, wr_mode, output wr_ready);
endinterface

// File: rtl/rgb_pwm_fader.sv
// Per-channel fading PWM; duty applied at period wrap, +1 cycle output register; wr_ready held high after reset.
// Backpressure: none, every write is taken in one cycle; optional breathe mode under RGB_PWM_BREATHE_EN.
module rgb_pwm_fader #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int RAMP_DIV = 48000,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    rgb_pwm_fader_if.slave      bus,
    output logic [CHANNELS-1:0] pwm,
    output logic [CHANNELS-1:0] busy
);
    localparam int               PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [WIDTH-1:0] DUTY_MAX = {WIDTH{1'b1}};

`ifdef RGB_PWM_BREATHE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_BUP, ST_BDN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP} state_t;
    logic w_unused_mode;
    assign w_unused_mode = bus.wr_mode;
`endif

    logic [WIDTH-1:0]    r_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic                r_rdy;
    logic [CHANNELS-1:0] r_pwm;
    logic [CHANNELS-1:0] r_busy;
    logic [WIDTH-1:0]    r_cur    [CHANNELS];
    logic [WIDTH-1:0]    r_tgt    [CHANNELS];
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    state_t              r_state  [CHANNELS];

    logic [WIDTH-1:0]    w_cur_nxt   [CHANNELS];
    logic [WIDTH-1:0]    w_tgt_nxt   [CHANNELS];
    state_t              w_state_nxt [CHANNELS];
    logic                w_tick;
    logic                w_acc;
    logic                w_wrap;

    assign w_tick = (r_pre == PRE_W'(RAMP_DIV - 1));
    assign w_acc  = bus.wr_valid & r_rdy;
    assign w_wrap = (r_cnt == DUTY_MAX);

    // A write to a channel takes priority over its tick: target moves, cur holds this edge.
    always_comb begin
        logic [WIDTH-1:0] v_cur;
        v_cur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v_cur          = r_cur[i];
            w_tgt_nxt[i]   = r_tgt[i];
            w_state_nxt[i] = r_state[i];
            if (w_acc && (bus.wr_chan == CH_W'(i))) begin
                w_tgt_nxt[i] = bus.wr_duty;
`ifdef RGB_PWM_BREATHE_EN
                if (bus.wr_mode && (bus.wr_duty != '0))
                    w_state_nxt[i] = (r_cur[i] < bus.wr_duty) ? ST_BUP : ST_BDN;
                else
`endif
                    w_state_nxt[i] = (bus.wr_duty == r_cur[i]) ? ST_IDLE : ST_RAMP;
            end else if (w_tick) begin
                case (r_state[i])
                    ST_RAMP: begin
                        if (r_cur[i] < r_tgt[i])
                            v_cur = r_cur[i] + WIDTH'(1);
                        else if (r_cur[i] > r_tgt[i])
                            v_cur = r_cur[i] - WIDTH'(1);
                        if (v_cur == r_tgt[i])
                            w_state_nxt[i] = ST_IDLE;
                    end
`ifdef RGB_PWM_BREATHE_EN
                    ST_BUP: begin
                        if (r_cur[i] < r_tgt[i])
                            v_cur = r_cur[i] + WIDTH'(1);
                        if (v_cur >= r_tgt[i])
                            w_state_nxt[i] = ST_BDN;
                    end
                    ST_BDN: begin
                        if (r_cur[i] != '0)
                            v_cur = r_cur[i] - WIDTH'(1);
                        if (v_cur == '0)
                            w_state_nxt[i] = ST_BUP;
                    end
`endif
                    default: ;
                endcase
            end
            w_cur_nxt[i] = v_cur;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_rdy  <= 1'b0;
            r_pwm  <= '0;
            r_busy <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i]    <= '0;
                r_tgt[i]    <= '0;
                r_shadow[i] <= '0;
                r_state[i]  <= ST_IDLE;
            end
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_rdy <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i]   <= w_cur_nxt[i];
                r_tgt[i]   <= w_tgt_nxt[i];
                r_state[i] <= w_state_nxt[i];
                if (w_wrap)
                    r_shadow[i] <= r_cur[i];
                // All-ones duty would otherwise lose one cycle per period.
                r_pwm[i]  <= (r_shadow[i] == DUTY_MAX) || (r_cnt < r_shadow[i]);
                r_busy[i] <= (r_state[i] != ST_IDLE);
            end
        end
    end

    assign bus.wr_ready = r_rdy;
    assign pwm          = r_pwm;
    assign busy         = r_busy;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader: expected cur steps are queued by the stimulus and popped by a monitor.
module tb_rgb_pwm_fader;
    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;
    localparam int RAMP_DIV = 4;
    localparam int CH_W     = 2;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] val;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [2:0]    pwm;
    logic [2:0]    busy;
    int            cyc;
    int            errors = 0;
    int            checks = 0;
    logic          mon_en = 1'b0;
    logic [3:0]    prev [3];
    exp_t          exp_q [$];

    rgb_pwm_fader_if #(.CH_W(CH_W), .WIDTH(WIDTH)) bus ();

    rgb_pwm_fader #(
        .CHANNELS(CHANNELS),
        .WIDTH   (WIDTH),
        .RAMP_DIV(RAMP_DIV),
        .CH_W    (CH_W)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pwm    (pwm),
        .busy   (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Edge index since reset release: ticks fall on multiples of 4, counter wraps on multiples of 16.
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int ch, input int val);
        exp_t e;
        e.ch  = 2'(ch);
        e.val = 4'(val);
        exp_q.push_back(e);
    endtask

    task automatic push_ramp(input int ch, input int from, input int to);
        int v = from;
        while (v != to) begin
            v = (to > v) ? v + 1 : v - 1;
            push(ch, v);
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (mon_en && rst_n && (dut.r_cur[i] != prev[i])) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("cur_unexpected_ch%0d", i), int'(dut.r_cur[i]), int'(prev[i]));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("cur_step ch*16+val"), i * 16 + int'(dut.r_cur[i]),
                          int'(e.ch) * 16 + int'(e.val));
                end
            end
            prev[i] = dut.r_cur[i];
        end
    end

    task automatic drive(input int ch, input int duty, input logic mode);
        bus.wr_valid = 1'b1;
        bus.wr_chan  = 2'(ch);
        bus.wr_duty  = 4'(duty);
        bus.wr_mode  = mode;
        check("wr_ready_at_write", int'(bus.wr_ready), 1);
        @(posedge sys_clk);
        #1 bus.wr_valid = 1'b0;
    endtask

    task automatic wr_now(input int ch, input int duty, input logic mode);
        @(negedge sys_clk);
        drive(ch, duty, mode);
    endtask

    // Issue a write that is accepted on edge index k.
    task automatic wr_at(input int k, input int ch, input int duty, input logic mode);
        int n = 0;
        @(negedge sys_clk);
        while (cyc != k - 1 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 3000) check("wr_at_timeout", cyc, k - 1);
        drive(ch, duty, mode);
    endtask

    task automatic wait_idle(input int ch);
        int n = 0;
        repeat (3) @(negedge sys_clk);
        while (busy[ch] && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 400) check($sformatf("settle_timeout_ch%0d", ch), int'(busy[ch]), 0);
        repeat (34) @(negedge sys_clk);
    endtask

    task automatic measure(input int ch, output int hi);
        hi = 0;
        repeat (16) begin
            @(negedge sys_clk);
            if (pwm[ch]) hi++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, bh, viol, lo;
        logic lastp;
        bus.wr_valid = 1'b0;
        bus.wr_chan  = '0;
        bus.wr_duty  = '0;
        bus.wr_mode  = 1'b0;

        // Reset: initial state, then a reset asserted mid-ramp clears everything at once.
        #2;
        check("por_wr_ready", int'(bus.wr_ready), 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        wr_now(2, 9, 1'b0);
        repeat (20) @(negedge sys_clk);
        check("busy_before_reset", int'(busy), 3'b100);
        @(posedge sys_clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_pwm", int'(pwm), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_ready", int'(bus.wr_ready), 0);
        check("reset_cur2", int'(dut.r_cur[2]), 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", int'(bus.wr_ready), 0);
        @(posedge sys_clk);
        #1 check("ready_after_first_edge", int'(bus.wr_ready), 1);
        mon_en = 1'b1;

        // Static duty on ch0: 5, full scale, zero.
        push_ramp(0, 0, 5);
        wr_now(0, 5, 1'b0);
        wait_idle(0);
        measure(0, hi);
        check("duty5_high_cycles", hi, 5);
        push_ramp(0, 5, 15);
        wr_now(0, 15, 1'b0);
        wait_idle(0);
        measure(0, hi);
        check("duty15_high_cycles", hi, 16);
        push_ramp(0, 15, 0);
        wr_now(0, 0, 1'b0);
        wait_idle(0);
        measure(0, hi);
        check("duty0_high_cycles", hi, 0);

        // Fade ch1 0->6, write on a tick edge: six steps 4 cycles apart, busy high 24 cycles.
        n = (cyc / 4 + 2) * 4;
        push_ramp(1, 0, 6);
        wr_at(n, 1, 6, 1'b0);
        bh = 0;
        viol = 0;
        lastp = pwm[1];
        repeat (40) begin
            @(negedge sys_clk);
            if (busy[1]) bh++;
            if (pwm[1] && !lastp && (cyc % 16) != 1) viol++;
            lastp = pwm[1];
        end
        check("fade_busy_cycles", bh, 24);
        check("pwm_rise_off_wrap", viol, 0);
        wait_idle(1);
        measure(1, hi);
        check("fade6_high_cycles", hi, 6);

        // Retarget ch2: 0->10, then 3 written on the tick that would have made cur 8.
        n = (cyc / 4 + 2) * 4 + 1;
        push_ramp(2, 0, 7);
        push_ramp(2, 7, 3);
        wr_at(n, 2, 10, 1'b0);
        wr_at(n + 31, 2, 3, 1'b0);
        while (cyc < n + 34) @(negedge sys_clk);
        check("hold_on_tick_cur2", int'(dut.r_cur[2]), 7);
        wait_idle(2);
        measure(2, hi);
        check("retarget3_high_cycles", hi, 3);

        // Out-of-range channel is accepted and ignored.
        wr_now(3, 9, 1'b0);
        repeat (12) @(negedge sys_clk);
        check("oor_busy", int'(busy), 0);
        check("oor_wr_ready", int'(bus.wr_ready), 1);

        // Back-to-back writes to ch0 and ch1, both stepping on the same ticks.
        n = (cyc / 4 + 2) * 4 + 1;
        push(0, 1); push(1, 5); push(0, 2); push(1, 4); push(1, 3);
        wr_at(n, 0, 2, 1'b0);
        wr_at(n + 1, 1, 3, 1'b0);
        wait_idle(1);
        check("b2b_busy", int'(busy), 0);
        measure(0, hi);
        check("b2b_ch0_high_cycles", hi, 2);
        measure(1, hi);
        check("b2b_ch1_high_cycles", hi, 3);

`ifdef RGB_PWM_BREATHE_EN
        push_ramp(0, 2, 0);
        wr_now(0, 0, 1'b0);
        wait_idle(0);
        n = (cyc / 4 + 2) * 4;
        push(0, 1); push(0, 2); push(0, 3); push(0, 4); push(0, 3);
        push(0, 2); push(0, 1); push(0, 0); push(0, 1); push(0, 2);
        wr_at(n, 0, 4, 1'b1);
        @(negedge sys_clk);
        lo = 0;
        repeat (36) begin
            @(negedge sys_clk);
            if (!busy[0]) lo++;
        end
        check("breathe_busy_low_cycles", lo, 0);
        wr_at(n + 38, 0, 2, 1'b0);
        wait_idle(0);
        check("breathe_exit_busy", int'(busy[0]), 0);
        measure(0, hi);
        check("breathe_exit_high_cycles", hi, 2);
`else
        lo = 0;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Multi-channel PWM generator with per-channel hardware fading, replacing the fixed-pattern LED driver that feeds the `SB_RGBA_DRV` PWM inputs. Each channel's duty is written through a valid/ready port and ramps toward its target one step per ramp tick. Duty changes apply only at PWM period boundaries, so outputs never glitch. It sits between control logic (or a soft CPU) and the RGB current-sink primitive, clocked from the `SB_HFOSC` system clock.

## Interface
- `CHANNELS`, 3: number of independent PWM channels (1–16)
- `WIDTH`, 8: duty and PWM counter width in bits (2–16); PWM period = 2^WIDTH cycles
- `RAMP_DIV`, 48000: sys_clk cycles per ramp tick (≥1)
- `CH_W`, derived: max(1, $clog2(CHANNELS))

Ports:
- `sys_clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accept
- `wr_chan`  in  CH_W  target channel index
- `wr_duty`  in  WIDTH  target duty
- `wr_mode`  in  1  0 = fade to target, 1 = breathe (ignored unless `RGB_PWM_BREATHE_EN`)
- `pwm`  out  CHANNELS  PWM outputs, to `RGBnPWM`
- `busy`  out  CHANNELS  channel not yet settled (ramping or breathing)

## Operation
- Reset is asynchronous: all state clears immediately on `rst_n` low. Reset values: `pwm`=0, `busy`=0, `wr_ready`=0, counters 0, cur/target/shadow duty 0, all channels IDLE.
- Free-running `cnt` (WIDTH bits) increments every cycle and wraps from 2^WIDTH−1 to 0.
- Ramp prescaler counts 0..RAMP_DIV−1. `tick` is a one-cycle pulse when the prescaler is at RAMP_DIV−1.
- Write handshake: a write is accepted on any edge with `wr_valid && wr_ready`.
  - `wr_ready` is 1 from the first edge after reset release.
  - If `wr_chan ≥ CHANNELS`, the write is accepted and discarded.
  - An accepted write sets `target[wr_chan] = wr_duty` and selects the mode.
- Per-channel FSM:
  - IDLE: cur == target, `busy`=0. A write with target ≠ cur → RAMP. A write with target == cur → stays IDLE.
  - RAMP: on `tick`, cur moves ±1 toward target. When cur == target → IDLE. A new write mid-ramp retargets from the current cur value; there is no restart.
  - BREATHE_UP / BREATHE_DOWN (macro only): on `tick`, cur +1 until cur == target, then → DOWN. In DOWN, cur −1 until 0, then → UP. `busy`=1 throughout. A breathe write with target 0 stays IDLE at 0.
  - A fade write (`wr_mode`=0) from any breathe state → RAMP toward the new target.
- Shadow duty: `shadow[i] ← cur[i]` on the edge where `cnt` wraps to 0.
- Output rule: `pwm[i]` = (`cnt` < `shadow[i]`), except `shadow[i]` = all-ones forces constant 1.
  - duty 0 → constant 0.
  - Otherwise high for `shadow` of the 2^WIDTH cycles in each period.
- Simultaneous `tick` and write to the same channel: the write wins for that edge (target updated, cur unchanged). Stepping resumes on the next tick.
- All arithmetic is unsigned WIDTH-bit. cur never under- or overflows, because stepping stops at target or 0.

## Timing
- `pwm`, `busy`, and `wr_ready` are registered outputs.
- Write accepted at edge N:
  - `target` is valid after N.
  - `busy` rises after N+1.
  - cur changes at the first `tick` after N.
- cur change → `pwm` effect: at the next `cnt` wrap (worst case 2^WIDTH cycles), plus 1 cycle of output register.
- Full-scale fade 0→2^WIDTH−1 takes (2^WIDTH−1)·RAMP_DIV cycles.

## Configuration
- `RGB_PWM_BREATHE_EN` defined: BREATHE_UP/DOWN states and `wr_mode` are active.
- Not defined:
  - `wr_mode` is ignored and every write is a fade.
  - The breathe states and their logic are not synthesised.
  - `busy` deasserts once cur == target.

## Test plan
Bench parameters: CHANNELS=3, WIDTH=4, RAMP_DIV=4.
- Reset: assert `rst_n`=0 mid-run → `pwm`=000, `busy`=000, `wr_ready`=0 immediately. After release, `wr_ready`=1 from the first edge.
- Static duty: write ch0 duty 5 → after settling, `pwm[0]` high exactly 5 of every 16 cycles. Duty 15 → constant 1. Duty 0 → constant 0.
- Fade: write ch1 duty 6 from 0 → cur steps 1 per 4 cycles, `busy[1]` high for 24 cycles then low. `pwm[1]` changes only at `cnt` wrap.
- Retarget mid-ramp: write ch2=10, then write ch2=3 when cur=7 → cur goes 7→6→5→4→3 with no jump to 0. A write coincident with a tick holds cur for that edge.
- Out-of-range and back-to-back writes: write chan 3 → accepted, no channel changes. Writes to ch0 and ch1 on consecutive cycles → both accepted and applied.
- Breathe (macro defined): write ch0 duty 4 with `wr_mode`=1 → cur sequence 0,1,2,3,4,3,2,1,0,1…, with `busy[0]` constantly 1. A fade write of 2 exits the breathe and settles at 2.
